mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Execute/memory stage of the Troy WideWord pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its decoded memory controls, register-write controls and instruction word, plus the 128-bit ALU result and store data.
- Performs 128-bit data-memory reads and writes over a req/ack handshake, stalling upstream while an access is outstanding.
- Registers the writeback bundle (destination, write enable, 128-bit result) for the MEM/WB side.

Parameters:
TIMEOUT_CYCLES, 255, max ACCESS cycles without dmem_ack before abort (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
valid_in  in  1  upstream bundle valid
memEn_in  in  1  memory op
memWrEn_in  in  1  1=store, 0=load (qualified by memEn_in)
memAddr_in  in  21  128-bit-word address
wbyteen_in  in  16  store byte enables; bit i -> bits [8i:8i+7]
wrdata_in  in  128  store data
alu_result_in  in  128  ALU result
regwren_in  in  1  register write enable
rwraddrd_in  in  5  destination register
reginmuxop_in  in  1  1=writeback load data, 0=ALU result
instruction_in  in  32  instruction word
stall_out  out  1  upstream must hold (combinational)
dmem_req  out  1  memory request
dmem_we  out  1  write strobe
dmem_addr  out  21  address
dmem_be  out  16  byte enables
dmem_wdata  out  128  write data
dmem_ack  in  1  access complete; rdata valid same cycle
dmem_rdata  in  128  read data
valid_out  out  1  writeback bundle valid
regwren_out  out  1  register write enable
rwraddrd_out  out  5  destination
wbdata_out  out  128  writeback data
instruction_out  out  32  instruction word
err_timeout  out  1  sticky timeout flag
stall_cnt  out  32  stall-cycle counter (optional feature)

Behaviour:
- Reset: clk and reset are single clock, synchronous active-high reset. Every registered output goes to 0, state=IDLE, timeout counter=0 and err_timeout=0. Reset mid-ACCESS drops dmem_req at the same edge; a late ack is then ignored.
- States: IDLE and ACCESS.
- IDLE, valid_in=1, memEn_in=0:
  - Next edge: valid_out=1; regwren_out, rwraddrd_out, instruction_out taken from the inputs; wbdata_out=alu_result_in. Latency 1.
  - stall_out=0.
- IDLE, valid_in=0: valid_out<=0 and regwren_out<=0; other outputs hold.
- IDLE, valid_in=1, memEn_in=1:
  - stall_out=1 combinationally in that cycle.
  - Next edge: capture all inputs, go to ACCESS, set dmem_req=1.
  - dmem_we=memWrEn_in; dmem_addr=memAddr_in; dmem_wdata=wrdata_in.
  - dmem_be=wbyteen_in for a store, 16'hFFFF for a load.
  - valid_out<=0.
- ACCESS:
  - Inputs are ignored; upstream re-presents the same op.
  - dmem_* outputs stay stable until ack.
  - stall_out = !(dmem_ack | timeout_hit).
  - Counter increments each cycle without ack; timeout_hit = (count == TIMEOUT_CYCLES-1) & !dmem_ack.
- ACCESS, dmem_ack=1:
  - Next edge: IDLE, dmem_req=0, counter=0, valid_out=1.
  - Captured regwren/rwraddrd/instruction are presented.
  - wbdata_out = captured reginmuxop ? dmem_rdata : captured alu_result.
  - Total latency for a memory op = 2 + ack wait cycles.
- ACCESS, timeout_hit:
  - Next edge: IDLE, dmem_req=0, err_timeout=1, valid_out=1.
  - regwren_out forced 0 (write suppressed); wbdata_out=0.
- dmem_ack while dmem_req=0 is ignored.
- Back-to-back memory ops: the second is accepted in the IDLE cycle after completion, because upstream advanced on the ack edge.
- err_timeout clears only on reset.

Optional Feature:
- Macro: DMEM_STALL_CNT_EN.
- Defined: stall_cnt is a 32-bit counter, reset to 0, incremented every cycle stall_out=1, wrapping 0xFFFFFFFF->0.
- Undefined: stall_cnt tied to 0 and no counter logic is built.

Test Plan:
- ALU op: valid_in=1, memEn_in=0, alu_result=128'hA5..A5, rwraddrd=5'd7, regwren=1 -> next cycle valid_out=1, wbdata_out=A5..A5, rwraddrd_out=7, stall_out never high.
- Store: addr=21'h00010, wbyteen=16'h00FF, data=128'h1122.. -> dmem_req=1, we=1, be=00FF held 3 cycles; ack on cycle 3 -> valid_out=1, regwren_out=0, stall_out low in the ack cycle.
- Load: reginmuxop=1, regwren=1, rwraddrd=5'd3, ack after 1 wait with rdata=128'hDEAD..BEEF -> wbdata_out=DEAD..BEEF, be=FFFF during access.
- Timeout, TIMEOUT_CYCLES=4, no ack -> dmem_req high 4 cycles then low, err_timeout=1, valid_out=1 with regwren_out=0.
- Reset asserted during ACCESS cycle 2 -> dmem_req=0 next edge, all outputs 0; ack one cycle later gives no valid_out.
- DMEM_STALL_CNT_EN defined: load with ack after 2 wait cycles (3 stall cycles) -> stall_cnt=3; undefined -> stall_cnt=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage -- execute/memory stage of the Troy WideWord pipeline.
//
// Takes the decoded bundle from the ID/EX register. ALU-only ops are passed
// to the writeback registers after one cycle. Memory ops run a 128-bit
// data-memory access over a req/ack handshake. While an access is
// outstanding, the stage holds upstream back with stall_out.
//
// Ports (summary):
//   clk, reset                  clock, synchronous active-high reset
//   valid_in .. instruction_in  decoded bundle from ID/EX
//   stall_out                   upstream hold request (combinational)
//   dmem_req/we/addr/be/wdata   registered data-memory request
//   dmem_ack, dmem_rdata        memory completion and read data
//   valid_out .. instruction_out  registered writeback bundle for MEM/WB
//   err_timeout                 sticky flag: an access was aborted
//   stall_cnt                   stall-cycle counter
//
// Optional feature: define DMEM_STALL_CNT_EN to build the 32-bit stall-cycle
// counter. When it is not defined, stall_cnt is tied to zero.

module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic         memEn_in,
  input  logic         memWrEn_in,
  input  logic [20:0]  memAddr_in,
  input  logic [15:0]  wbyteen_in,
  input  logic [127:0] wrdata_in,
  input  logic [127:0] alu_result_in,
  input  logic         regwren_in,
  input  logic [4:0]   rwraddrd_in,
  input  logic         reginmuxop_in,
  input  logic [31:0]  instruction_in,
  output logic         stall_out,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [20:0]  dmem_addr,
  output logic [15:0]  dmem_be,
  output logic [127:0] dmem_wdata,
  input  logic         dmem_ack,
  input  logic [127:0] dmem_rdata,
  output logic         valid_out,
  output logic         regwren_out,
  output logic [4:0]   rwraddrd_out,
  output logic [127:0] wbdata_out,
  output logic [31:0]  instruction_out,
  output logic         err_timeout,
  output logic [31:0]  stall_cnt
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           req_q, req_d, we_q, we_d;
  logic [20:0]    addr_q, addr_d;
  logic [15:0]    be_q, be_d;
  logic [127:0]   wdata_q, wdata_d;
  // Bundle fields captured at accept, for presentation after the access.
  logic           cap_regwren_q, cap_regwren_d, cap_mux_q, cap_mux_d;
  logic [4:0]     cap_rd_q, cap_rd_d;
  logic [31:0]    cap_instr_q, cap_instr_d;
  logic [127:0]   cap_alu_q, cap_alu_d;
  logic           valid_q, valid_d, regwren_q, regwren_d, err_q, err_d;
  logic [4:0]     rd_q, rd_d;
  logic [127:0]   wb_q, wb_d;
  logic [31:0]    instr_q, instr_d;
  logic           timeout_hit_s;

  // An ack in the same cycle as the last allowed count wins over the abort.
  assign timeout_hit_s = (state_q == ACCESS) && (cnt_q == TO_LAST) && !dmem_ack;
  assign stall_out = (state_q == IDLE) ? (valid_in & memEn_in)
                                       : !(dmem_ack | timeout_hit_s);

  // Next-state and next-output logic for the IDLE/ACCESS controller.
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;
    req_d = req_q;  we_d = we_q;  addr_d = addr_q;  be_d = be_q;  wdata_d = wdata_q;
    cap_regwren_d = cap_regwren_q;  cap_mux_d = cap_mux_q;  cap_rd_d = cap_rd_q;
    cap_instr_d = cap_instr_q;  cap_alu_d = cap_alu_q;
    valid_d = valid_q;  regwren_d = regwren_q;  rd_d = rd_q;  wb_d = wb_q;
    instr_d = instr_q;  err_d = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (valid_in && memEn_in) begin
          state_d = ACCESS;
          req_d = 1'b1;
          we_d = memWrEn_in;
          addr_d = memAddr_in;
          be_d = memWrEn_in ? wbyteen_in : 16'hFFFF;
          wdata_d = wrdata_in;
          cap_regwren_d = regwren_in;
          cap_mux_d = reginmuxop_in;
          cap_rd_d = rwraddrd_in;
          cap_instr_d = instruction_in;
          cap_alu_d = alu_result_in;
          valid_d = 1'b0;
        end else if (valid_in) begin
          valid_d = 1'b1;
          regwren_d = regwren_in;
          rd_d = rwraddrd_in;
          instr_d = instruction_in;
          wb_d = alu_result_in;
        end else begin
          valid_d = 1'b0;
          regwren_d = 1'b0;
        end
      end
      ACCESS: begin
        valid_d = 1'b0;
        if (dmem_ack) begin
          state_d = IDLE;
          req_d = 1'b0;
          cnt_d = 8'd0;
          valid_d = 1'b1;
          regwren_d = cap_regwren_q;
          rd_d = cap_rd_q;
          instr_d = cap_instr_q;
          wb_d = cap_mux_q ? dmem_rdata : cap_alu_q;
        end else if (timeout_hit_s) begin
          state_d = IDLE;
          req_d = 1'b0;
          cnt_d = 8'd0;
          err_d = 1'b1;
          valid_d = 1'b1;
          regwren_d = 1'b0;
          rd_d = cap_rd_q;
          instr_d = cap_instr_q;
          wb_d = 128'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d = 1'b0;
        cnt_d = 8'd0;
      end
    endcase
  end

  // State and output registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;  cnt_q <= 8'd0;
      req_q <= 1'b0;  we_q <= 1'b0;  addr_q <= 21'd0;  be_q <= 16'd0;  wdata_q <= 128'd0;
      cap_regwren_q <= 1'b0;  cap_mux_q <= 1'b0;  cap_rd_q <= 5'd0;
      cap_instr_q <= 32'd0;  cap_alu_q <= 128'd0;
      valid_q <= 1'b0;  regwren_q <= 1'b0;  rd_q <= 5'd0;  wb_q <= 128'd0;
      instr_q <= 32'd0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;
      req_q <= req_d;  we_q <= we_d;  addr_q <= addr_d;  be_q <= be_d;  wdata_q <= wdata_d;
      cap_regwren_q <= cap_regwren_d;  cap_mux_q <= cap_mux_d;  cap_rd_q <= cap_rd_d;
      cap_instr_q <= cap_instr_d;  cap_alu_q <= cap_alu_d;
      valid_q <= valid_d;  regwren_q <= regwren_d;  rd_q <= rd_d;  wb_q <= wb_d;
      instr_q <= instr_d;  err_q <= err_d;
    end
  end

  assign dmem_req = req_q;
  assign dmem_we = we_q;
  assign dmem_addr = addr_q;
  assign dmem_be = be_q;
  assign dmem_wdata = wdata_q;
  assign valid_out = valid_q;
  assign regwren_out = regwren_q;
  assign rwraddrd_out = rd_q;
  assign wbdata_out = wb_q;
  assign instruction_out = instr_q;
  assign err_timeout = err_q;

`ifdef DMEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count every cycle in which upstream is held. The counter wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall_out) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in, memEn_in, memWrEn_in, regwren_in, reginmuxop_in;
  logic [20:0]  memAddr_in;
  logic [15:0]  wbyteen_in;
  logic [127:0] wrdata_in, alu_result_in, dmem_rdata;
  logic [4:0]   rwraddrd_in;
  logic [31:0]  instruction_in;
  logic         stall_out, dmem_req, dmem_we, dmem_ack;
  logic [20:0]  dmem_addr;
  logic [15:0]  dmem_be;
  logic [127:0] dmem_wdata, wbdata_out;
  logic         valid_out, regwren_out, err_timeout;
  logic [4:0]   rwraddrd_out;
  logic [31:0]  instruction_out, stall_cnt;

  int total = 0;
  int bad = 0;

  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] DB   = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] SD   = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00;
  localparam logic [127:0] SALU = 128'h0000_0000_0000_0000_0000_0000_00C0_FFEE;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .memEn_in(memEn_in),
    .memWrEn_in(memWrEn_in), .memAddr_in(memAddr_in), .wbyteen_in(wbyteen_in),
    .wrdata_in(wrdata_in), .alu_result_in(alu_result_in), .regwren_in(regwren_in),
    .rwraddrd_in(rwraddrd_in), .reginmuxop_in(reginmuxop_in),
    .instruction_in(instruction_in), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .valid_out(valid_out), .regwren_out(regwren_out), .rwraddrd_out(rwraddrd_out),
    .wbdata_out(wbdata_out), .instruction_out(instruction_out),
    .err_timeout(err_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; memEn_in = 1'b0; memWrEn_in = 1'b0; memAddr_in = 21'd0;
    wbyteen_in = 16'd0; wrdata_in = 128'd0; alu_result_in = 128'd0;
    regwren_in = 1'b0; rwraddrd_in = 5'd0; reginmuxop_in = 1'b0;
    instruction_in = 32'd0; dmem_ack = 1'b0; dmem_rdata = 128'd0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_wb", wbdata_out, 128'd0);
    chk("rst_scnt", stall_cnt, 32'd0);
    reset = 1'b0;

    // Load, ack after 2 wait cycles.
    valid_in = 1'b1; memEn_in = 1'b1; memWrEn_in = 1'b0; memAddr_in = 21'h00020;
    wbyteen_in = 16'h0F0F; reginmuxop_in = 1'b1; regwren_in = 1'b1;
    rwraddrd_in = 5'd3; alu_result_in = A5; instruction_in = 32'hCAFE_0003;
    #1 chk("ld_stall_idle", stall_out, 1'b1);
    tick();
    chk("ld_req", dmem_req, 1'b1);
    chk("ld_we", dmem_we, 1'b0);
    chk("ld_be", dmem_be, 16'hFFFF);
    chk("ld_addr", dmem_addr, 21'h00020);
    chk("ld_valid_acc", valid_out, 1'b0);
    #1 chk("ld_stall_w1", stall_out, 1'b1);
    tick(); tick();
    dmem_ack = 1'b1; dmem_rdata = DB;
    #1 chk("ld_stall_ack", stall_out, 1'b0);
    tick();
    dmem_ack = 1'b0; valid_in = 1'b0;
    chk("ld_valid", valid_out, 1'b1);
    chk("ld_wb", wbdata_out, DB);
    chk("ld_rd", rwraddrd_out, 5'd3);
    chk("ld_rwen", regwren_out, 1'b1);
    chk("ld_instr", instruction_out, 32'hCAFE_0003);
    chk("ld_req_done", dmem_req, 1'b0);
`ifdef DMEM_STALL_CNT_EN
    chk("ld_scnt", stall_cnt, 32'd3);
`else
    chk("ld_scnt", stall_cnt, 32'd0);
`endif

    // ALU op.
    idle_inputs();
    valid_in = 1'b1; alu_result_in = A5; rwraddrd_in = 5'd7; regwren_in = 1'b1;
    instruction_in = 32'h1234_5678;
    #1 chk("alu_stall", stall_out, 1'b0);
    tick();
    chk("alu_valid", valid_out, 1'b1);
    chk("alu_wb", wbdata_out, A5);
    chk("alu_rd", rwraddrd_out, 5'd7);
    chk("alu_rwen", regwren_out, 1'b1);
    chk("alu_instr", instruction_out, 32'h1234_5678);
    valid_in = 1'b0;
    tick();
    chk("bub_valid", valid_out, 1'b0);
    chk("bub_rwen", regwren_out, 1'b0);
    chk("bub_wb_hold", wbdata_out, A5);

    // Store, ack in the third access cycle.
    valid_in = 1'b1; memEn_in = 1'b1; memWrEn_in = 1'b1; memAddr_in = 21'h00010;
    wbyteen_in = 16'h00FF; wrdata_in = SD; alu_result_in = SALU;
    regwren_in = 1'b0; reginmuxop_in = 1'b0; instruction_in = 32'h0000_0510;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_req%0d", i), dmem_req, 1'b1);
      chk($sformatf("st_we%0d", i), dmem_we, 1'b1);
      chk($sformatf("st_be%0d", i), dmem_be, 16'h00FF);
      chk($sformatf("st_wd%0d", i), dmem_wdata, SD);
      if (i == 2) begin
        dmem_ack = 1'b1;
        #1 chk("st_stall_ack", stall_out, 1'b0);
      end else begin
        #1 chk($sformatf("st_stall%0d", i), stall_out, 1'b1);
      end
      tick();
    end
    dmem_ack = 1'b0; valid_in = 1'b0;
    chk("st_valid", valid_out, 1'b1);
    chk("st_rwen", regwren_out, 1'b0);
    chk("st_wb", wbdata_out, SALU);
    chk("st_req_done", dmem_req, 1'b0);

    // Timeout: no ack, four access cycles.
    valid_in = 1'b1; memEn_in = 1'b1; memWrEn_in = 1'b0; regwren_in = 1'b1;
    reginmuxop_in = 1'b1; rwraddrd_in = 5'd9;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), dmem_req, 1'b1);
      #1 chk($sformatf("to_stall%0d", i), stall_out, (i == 3) ? 1'b0 : 1'b1);
      tick();
    end
    valid_in = 1'b0;
    chk("to_req_done", dmem_req, 1'b0);
    chk("to_err", err_timeout, 1'b1);
    chk("to_valid", valid_out, 1'b1);
    chk("to_rwen", regwren_out, 1'b0);
    chk("to_wb", wbdata_out, 128'd0);
    tick();
    chk("to_err_sticky", err_timeout, 1'b1);

    // Reset during the second access cycle, then a late ack.
    valid_in = 1'b1; memEn_in = 1'b1; instruction_in = 32'hFFFF_0001;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; valid_in = 1'b0; memEn_in = 1'b0;
    chk("mr_req", dmem_req, 1'b0);
    chk("mr_valid", valid_out, 1'b0);
    chk("mr_err", err_timeout, 1'b0);
    chk("mr_wb", wbdata_out, 128'd0);
    chk("mr_instr", instruction_out, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = DB;
    #1 chk("mr_stall", stall_out, 1'b0);
    tick();
    dmem_ack = 1'b0;
    chk("late_valid", valid_out, 1'b0);
    chk("late_wb", wbdata_out, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
